// File: rtl/led7seg_scan_if.sv
// Display bus between the countdown controller and the 7-segment scanner.
// Combinational bundle of signals with no latency of its own.
// No backpressure: loads are fire-and-forget strobes, and display pins are free-running.
interface led7seg_scan_if #(
    parameter int N_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*N_DIGITS-1:0]   bcd_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [N_DIGITS-1:0]     dig_sel;
    logic                    frame_tick;

    // Controller side: supplies codes and strobes, and watches the pins and the frame tick.
    modport master (
        output enable, load, bcd_in, dp_in,
        input  seg, dp, dig_sel, frame_tick
    );

    // Display driver side.
    modport slave (
        input  enable, load, bcd_in, dp_in,
        output seg, dp, dig_sel, frame_tick
    );
endinterface

// File: rtl/led7seg_scan.sv
// Time-multiplexed common-anode 7-segment scanner with blanking, LZ suppression and double buffer.
// Pins are registered from the scan position, display buffer and enable: 1 clk latency.
// No backpressure: a load is always accepted into the pending buffer and shown from the next frame.
module led7seg_scan #(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 500,
    parameter bit HEX_MODE    = 1'b0,
    parameter bit LZ_SUPPRESS = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    led7seg_scan_if.slave    bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    BLANK_V  = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] DIG_OFF  = DIG_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [6:0]          SEG_OFF  = 7'h7F;

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*N_DIGITS-1:0]   r_disp_bcd;
    logic [N_DIGITS-1:0]     r_disp_dp;
    logic [4*N_DIGITS-1:0]   r_pend_bcd;
    logic [N_DIGITS-1:0]     r_pend_dp;
    logic                    r_pend_vld;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [N_DIGITS-1:0]     r_dig;
    logic                    r_tick;

    logic                    w_cnt_last;
    logic                    w_wrap;
    logic                    w_on;
    logic [3:0]              w_codes [N_DIGITS];
    logic [N_DIGITS-1:0]     w_lz_blank;
    logic [N_DIGITS-1:0]     w_onehot;
    logic [6:0]              w_seg;

    // Active-low glyph for one 4-bit code; codes above 9 depend on HEX_MODE.
    function automatic logic [6:0] f_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b100_0000;
            4'd1:    s = 7'b111_1001;
            4'd2:    s = 7'b010_0100;
            4'd3:    s = 7'b011_0000;
            4'd4:    s = 7'b001_1001;
            4'd5:    s = 7'b001_0010;
            4'd6:    s = 7'b000_0010;
            4'd7:    s = 7'b111_1000;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b001_0000;
            4'd10:   s = HEX_MODE ? 7'b000_1000 : SEG_OFF;
            4'd11:   s = HEX_MODE ? 7'b000_0011 : SEG_OFF;
            4'd12:   s = HEX_MODE ? 7'b100_0110 : SEG_OFF;
            4'd13:   s = HEX_MODE ? 7'b010_0001 : SEG_OFF;
            4'd14:   s = HEX_MODE ? 7'b000_0110 : SEG_OFF;
            default: s = HEX_MODE ? 7'b000_1110 : SEG_OFF;
        endcase
        return s;
    endfunction

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_wrap     = w_cnt_last && (r_idx == IDX_LAST);
    assign w_on       = bus.enable && (r_cnt >= BLANK_V);

    genvar g;
    for (g = 0; g < N_DIGITS; g++) begin : g_codes
        assign w_codes[g] = r_disp_bcd[4*g +: 4];
    end

    // Walk from the most significant digit down, blanking zeros until the first non-zero digit.
    always_comb begin
        logic v_zero_above;
        v_zero_above = 1'b1;
        w_lz_blank   = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            v_zero_above  = v_zero_above && (w_codes[k] == 4'd0);
            w_lz_blank[k] = LZ_SUPPRESS && (k != 0) && v_zero_above;
        end
    end

    // One-hot select of the digit currently being scanned.
    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
    end

    assign w_seg = w_lz_blank[r_idx] ? SEG_OFF : f_decode(w_codes[r_idx]);

    // Slot prescaler and digit index; the index wraps to digit 0 after the last slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Double buffer: loads land in pending; display only changes on the frame wrap edge.
    // A load on the wrap edge itself is held in pending and appears one frame later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_bcd <= '0;
            r_pend_dp  <= '0;
            r_pend_vld <= 1'b0;
            r_disp_bcd <= '0;
            r_disp_dp  <= '0;
        end else begin
            if (w_wrap && r_pend_vld) begin
                r_disp_bcd <= r_pend_bcd;
                r_disp_dp  <= r_pend_dp;
            end
            if (bus.load) begin
                r_pend_bcd <= bus.bcd_in;
                r_pend_dp  <= bus.dp_in;
                r_pend_vld <= 1'b1;
            end else if (w_wrap) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // Registered pins: dark during the anti-ghost window or when disabled; frame tick on wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg  <= SEG_OFF;
            r_dp   <= 1'b1;
            r_dig  <= DIG_OFF;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (w_on) begin
                r_seg <= w_seg;
                r_dp  <= ~r_disp_dp[r_idx];
                r_dig <= DIG_ACT_LOW ? ~w_onehot : w_onehot;
            end else begin
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
                r_dig <= DIG_OFF;
            end
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.dig_sel    = r_dig;
    assign bus.frame_tick = r_tick;
endmodule

// File: tb/tb_led7seg_scan.sv
// Bench for led7seg_scan: two instances (hex+LZ, decimal without LZ) share one stimulus stream.
// Expected pins come from a frame-position model of the display rules, one clk behind the scan.
// Inputs change on the falling edge; pins are compared on every falling edge.
module tb_led7seg_scan;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int FR = N * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led7seg_scan_if #(.N_DIGITS(N)) bus_h ();
    led7seg_scan_if #(.N_DIGITS(N)) bus_d ();

    assign bus_d.enable = bus_h.enable;
    assign bus_d.load   = bus_h.load;
    assign bus_d.bcd_in = bus_h.bcd_in;
    assign bus_d.dp_in  = bus_h.dp_in;

    led7seg_scan #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(1), .HEX_MODE(1'b1),
                   .LZ_SUPPRESS(1'b1), .DIG_ACT_LOW(1'b1))
        dut_h (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_h.slave));

    led7seg_scan #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(1), .HEX_MODE(1'b0),
                   .LZ_SUPPRESS(1'b0), .DIG_ACT_LOW(1'b1))
        dut_d (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_d.slave));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
    endtask

    // Glyph table, active-low {g..a}; entries 10..15 are the hex letters.
    logic [6:0] glyph [16];
    initial begin
        glyph[0]  = 7'b100_0000; glyph[1]  = 7'b111_1001; glyph[2]  = 7'b010_0100;
        glyph[3]  = 7'b011_0000; glyph[4]  = 7'b001_1001; glyph[5]  = 7'b001_0010;
        glyph[6]  = 7'b000_0010; glyph[7]  = 7'b111_1000; glyph[8]  = 7'b000_0000;
        glyph[9]  = 7'b001_0000; glyph[10] = 7'b000_1000; glyph[11] = 7'b000_0011;
        glyph[12] = 7'b100_0110; glyph[13] = 7'b010_0001; glyph[14] = 7'b000_0110;
        glyph[15] = 7'b000_1110;
    end

    function automatic bit lit(input int pos, input logic en);
        return en && ((pos % SD) >= 1);
    endfunction

    function automatic logic [6:0] exp_seg(input bit hex, input bit lz, input logic [15:0] disp,
                                           input int pos, input logic en);
        int k;
        logic [15:0] upper;
        logic [3:0] code;
        if (!lit(pos, en)) return 7'h7F;
        k     = pos / SD;
        upper = disp >> (4 * k);
        code  = upper[3:0];
        if (lz && k > 0 && upper == 16'h0) return 7'h7F;
        if (code > 4'd9 && !hex) return 7'h7F;
        return glyph[code];
    endfunction

    // Reference model: frame position (0..FR-1), display and pending buffers.
    int          m_pos;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_ddp, m_pdp;
    logic        m_pv;
    logic [6:0]  e_seg_h, e_seg_d;
    logic        e_dp, e_tick;
    logic [3:0]  e_dig;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= 0; m_disp <= '0; m_pend <= '0; m_ddp <= '0; m_pdp <= '0; m_pv <= 1'b0;
            e_seg_h <= 7'h7F; e_seg_d <= 7'h7F; e_dp <= 1'b1; e_dig <= 4'hF; e_tick <= 1'b0;
        end else begin
            e_tick  <= (m_pos == FR - 1);
            e_seg_h <= exp_seg(1'b1, 1'b1, m_disp, m_pos, bus_h.enable);
            e_seg_d <= exp_seg(1'b0, 1'b0, m_disp, m_pos, bus_h.enable);
            e_dp    <= lit(m_pos, bus_h.enable) ? ~m_ddp[m_pos / SD] : 1'b1;
            e_dig   <= lit(m_pos, bus_h.enable) ? ~(4'b0001 << (m_pos / SD)) : 4'hF;
            if (m_pos == FR - 1 && m_pv) begin
                m_disp <= m_pend;
                m_ddp  <= m_pdp;
            end
            if (bus_h.load) begin
                m_pend <= bus_h.bcd_in;
                m_pdp  <= bus_h.dp_in;
                m_pv   <= 1'b1;
            end else if (m_pos == FR - 1) begin
                m_pv <= 1'b0;
            end
            m_pos <= (m_pos + 1) % FR;
        end
    end

    bit run_chk = 1'b0;

    // Every falling edge: all pins of both instances against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("seg_hex", bus_h.seg, e_seg_h);
            chk("seg_dec", bus_d.seg, e_seg_d);
            chk("dp_hex", bus_h.dp, e_dp);
            chk("dp_dec", bus_d.dp, e_dp);
            chk("dig_hex", bus_h.dig_sel, e_dig);
            chk("dig_dec", bus_d.dig_sel, e_dig);
            chk("tick_hex", bus_h.frame_tick, e_tick);
            chk("tick_dec", bus_d.frame_tick, e_tick);
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus_h.load   = 1'b1;
        bus_h.bcd_in = v;
        bus_h.dp_in  = d;
        @(negedge clk);
        bus_h.load   = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (m_pos != p && n < 4 * FR) begin
            @(negedge clk);
            n++;
        end
        chk("wait_pos_bound", 32'(m_pos), 32'(p));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] v;
        int nz;
        bus_h.enable = 1'b1;
        bus_h.load   = 1'b0;
        bus_h.bcd_in = '0;
        bus_h.dp_in  = '0;
        run_chk = 1'b1;
        idle(3);
        rst_n = 1'b1;

        do_load(16'h1234, 4'h0);        idle(2 * FR + 4);
        do_load(16'h0007, 4'b1010);     idle(2 * FR + 4);
        do_load(16'h0000, 4'h0);        idle(2 * FR + 4);
        do_load(16'h00AF, 4'b0001);     idle(2 * FR + 4);
        do_load(16'h0A0C, 4'h0);        idle(2 * FR + 4);

        wait_pos(9);  do_load(16'h5555, 4'h0);  idle(4);
        wait_pos(FR - 1); do_load(16'h9876, 4'b1100); idle(2 * FR + 4);
        wait_pos(2);  do_load(16'h1111, 4'h0);  do_load(16'h2468, 4'b0110); idle(2 * FR + 4);

        bus_h.enable = 1'b0; idle(20);
        bus_h.enable = 1'b1; idle(FR + 4);

        wait_pos(10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", bus_h.seg, 7'h7F);
        chk("arst_dig", bus_h.dig_sel, 4'hF);
        chk("arst_dp", bus_h.dp, 1'b1);
        chk("arst_tick", bus_h.frame_tick, 1'b0);
        idle(3);
        rst_n = 1'b1;
        idle(2 * FR + 4);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 49) == 0) bus_h.enable = ~bus_h.enable;
            if ($urandom_range(0, 9) == 0) begin
                nz = $urandom_range(0, 4);
                v  = 16'($urandom);
                if (nz < 4) v = v & 16'((32'h1 << (4 * nz)) - 1);
                do_load(v, 4'($urandom));
            end else begin
                @(negedge clk);
            end
        end

        run_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
